// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//
// Control FSM for the 4-bit calculator datapath. Operand A, operand B and an
// opcode are captured from the board switches on debounced enter pulses. The
// sequencer then drives an external 4-bit add/sub unit: a single pass for
// add/sub, or a 4-iteration unsigned shift-add loop for multiply. The 8-bit
// result and status flags are held for the display block until the next enter.
//
// Optional feature (macro CALC_CHAIN_EN):
//   defined   - enter in DONE loads A with the low nibble of the result and
//               goes straight to GET_B, so answers chain into the next sum.
//   undefined - enter in DONE goes to GET_A and A is reloaded from switches.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   sw        operand value from switches
//   op        opcode, sampled with B: 00 add, 01 sub, 10 mul, 11 reserved
//   enter     single-cycle debounced button pulse
//   add_x     adder operand x (combinational)
//   add_y     adder operand y (combinational)
//   add_sub   adder mode, 1 = subtract (combinational)
//   add_res   adder sum
//   add_cout  adder carry-out
//   add_ovf   adder signed overflow
//   result    final result, registered
//   overflow  signed overflow of the last add/sub, registered
//   err       reserved opcode used, registered
//   busy      high in EXEC and MUL
//   done      high in DONE
//   state     state encoding for debug LEDs
//             (0 GET_A, 1 GET_B, 2 EXEC, 3 MUL, 4 DONE)
// ---------------------------------------------------------------------------
module calc_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     sw,
    input  logic [1:0]           op,
    input  logic                 enter,
    output logic [WIDTH-1:0]     add_x,
    output logic [WIDTH-1:0]     add_y,
    output logic                 add_sub,
    input  logic [WIDTH-1:0]     add_res,
    input  logic                 add_cout,
    input  logic                 add_ovf,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow,
    output logic                 err,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_GET_A = 3'd0,
        S_GET_B = 3'd1,
        S_EXEC  = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [1:0]           opcode_q;
    logic [WIDTH-1:0]     acc_q, q_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 overflow_q, err_q;

    // Post-shift accumulator/multiplier values for one shift-add iteration.
    logic [WIDTH-1:0]     acc_shift, q_shift;
    logic                 mul_last;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_GET_A;
        else        state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // Next state and adder operand steering
    // -----------------------------------------------------------------------
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;

        case (state_q)
            S_GET_A: if (enter) state_d = S_GET_B;
            S_GET_B: if (enter) state_d = S_EXEC;
            S_EXEC: begin
                add_x   = a_q;
                add_y   = b_q;
                add_sub = opcode_q[0];
                state_d = (opcode_q == OP_MUL) ? S_MUL : S_DONE;
            end
            S_MUL: begin
                add_x = acc_q;
                add_y = a_q;
                if (mul_last) state_d = S_DONE;
            end
            S_DONE: begin
`ifdef CALC_CHAIN_EN
                if (enter) state_d = S_GET_B;
`else
                if (enter) state_d = S_GET_A;
`endif
            end
            default: state_d = S_GET_A;
        endcase
    end

    // One shift-add step: when the multiplier LSB is set the adder sum (with
    // its carry) is shifted in, otherwise the accumulator just shifts right.
    always_comb begin
        if (q_q[0]) {acc_shift, q_shift} = {add_cout, add_res, q_q[WIDTH-1:1]};
        else        {acc_shift, q_shift} = {1'b0,     acc_q,   q_q[WIDTH-1:1]};
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // NOTE: these are plain flops, not a memory array, so all of them are
    // cleared by reset; a reset mid-multiply therefore leaves no partial
    // product behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            opcode_q   <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_GET_A: begin
                    if (enter) a_q <= sw;
                end
                S_GET_B: begin
                    if (enter) begin
                        b_q      <= sw;
                        opcode_q <= op;
                    end
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_ADD, OP_SUB: begin
                            result_q   <= {{WIDTH{add_res[WIDTH-1]}}, add_res};
                            overflow_q <= add_ovf;
                            err_q      <= 1'b0;
                        end
                        OP_MUL: begin
                            acc_q      <= '0;
                            q_q        <= b_q;
                            cnt_q      <= '0;
                            overflow_q <= 1'b0;
                            err_q      <= 1'b0;
                        end
                        default: begin
                            result_q   <= '0;
                            overflow_q <= 1'b0;
                            err_q      <= 1'b1;
                        end
                    endcase
                end
                S_MUL: begin
                    acc_q <= acc_shift;
                    q_q   <= q_shift;
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_last) result_q <= {acc_shift, q_shift};
                end
                S_DONE: begin
                    if (enter) begin
`ifdef CALC_CHAIN_EN
                        a_q <= result_q[WIDTH-1:0];
`endif
                        result_q   <= '0;
                        overflow_q <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign result   = result_q;
    assign overflow = overflow_q;
    assign err      = err_q;
    assign busy     = (state_q == S_EXEC) || (state_q == S_MUL);
    assign done     = (state_q == S_DONE);
    assign state    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
//
// Self-checking bench for calc_sequencer. Provides a behavioural 4-bit
// add/sub unit on the adder ports, applies a table of directed vectors,
// hand-written sequences for ignored enter, reset mid-multiply and result
// chaining, then randomized operations against an arithmetic reference model.
// Define CALC_CHAIN_EN for both files to exercise the chaining build.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam int WIDTH = 4;
    localparam logic [2:0] ST_GET_A = 3'd0;
    localparam logic [2:0] ST_GET_B = 3'd1;
    localparam logic [2:0] ST_MUL   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam int TIMEOUT = 20;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH-1:0]   sw;
    logic [1:0]         op;
    logic               enter;
    logic [WIDTH-1:0]   add_x, add_y, add_res;
    logic               add_sub, add_cout, add_ovf;
    logic [2*WIDTH-1:0] result;
    logic               overflow, err, busy, done;
    logic [2:0]         state;

    int n_pass  = 0;
    int n_total = 0;

    calc_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .op       (op),
        .enter    (enter),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_sub  (add_sub),
        .add_res  (add_res),
        .add_cout (add_cout),
        .add_ovf  (add_ovf),
        .result   (result),
        .overflow (overflow),
        .err      (err),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    // External 4-bit add/sub unit: x + y, or x + ~y + 1 when subtracting.
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   sum_full;
    always_comb begin
        y_eff    = add_sub ? ~add_y : add_y;
        sum_full = {1'b0, add_x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, add_sub};
        add_res  = sum_full[WIDTH-1:0];
        add_cout = sum_full[WIDTH];
        add_ovf  = (add_x[WIDTH-1] == y_eff[WIDTH-1]) &&
                   (sum_full[WIDTH-1] != add_x[WIDTH-1]);
    end

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter(input logic [3:0] v, input logic [1:0] o);
        sw    = v;
        op    = o;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Called right after the B enter. Returns cycles from that enter until
    // done, plus the number of busy cycles seen. Optionally pulses enter
    // while the DUT is busy (it must be ignored).
    task automatic wait_done(input bit inject, output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_cnt++;
            enter = inject && (lat == 3 || (lat == 1));
            sw    = 4'($urandom);
            tick();
            enter = 1'b0;
            lat++;
        end
    endtask

    // Reference model from the arithmetic rules.
    task automatic ref_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                             output logic [7:0] r, output logic ovf, output logic e,
                             output int lat);
        int sa, sb, s;
        logic [3:0] t;
        sa = $signed(a);
        sb = $signed(b);
        r = 8'h00; ovf = 1'b0; e = 1'b0; lat = 2;
        case (o)
            2'b00, 2'b01: begin
                s   = (o == 2'b00) ? sa + sb : sa - sb;
                ovf = (s > 7) || (s < -8);
                t   = 4'(s);
                r   = 8'($signed(t));
            end
            2'b10: begin
                r   = 8'(int'(a) * int'(b));
                lat = 6;
            end
            default: e = 1'b1;
        endcase
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] r;
        logic       ovf;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, bcnt;
        logic [7:0] er;
        logic eo, ee;
        int el;
        logic [3:0] a_cur;
        bit have_a;

        vecs[0] = '{4'd3,  4'd2,  2'b00, 8'h05, 1'b0, 1'b0, 2};
        vecs[1] = '{4'd3,  4'd5,  2'b01, 8'hFE, 1'b0, 1'b0, 2};
        vecs[2] = '{4'd7,  4'd1,  2'b00, 8'hF8, 1'b1, 1'b0, 2};
        vecs[3] = '{4'd8,  4'd1,  2'b01, 8'h07, 1'b1, 1'b0, 2};
        vecs[4] = '{4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 1'b0, 6};
        vecs[5] = '{4'd0,  4'd9,  2'b10, 8'h00, 1'b0, 1'b0, 6};
        vecs[6] = '{4'd3,  4'd3,  2'b11, 8'h00, 1'b0, 1'b1, 2};

        rst_n = 1'b0; sw = '0; op = '0; enter = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        check("reset_state",    state,    ST_GET_A);
        check("reset_result",   result,   0);
        check("reset_overflow", overflow, 0);
        check("reset_err",      err,      0);
        check("reset_busy",     busy,     0);
        check("reset_done",     done,     0);
        check("idle_add_x",     add_x,    0);

        // Directed table
        foreach (vecs[i]) begin
            pulse_enter(vecs[i].a, 2'b00);
            check("vec_state_get_b", state, ST_GET_B);
            pulse_enter(vecs[i].b, vecs[i].op);
            wait_done(1'b0, lat, bcnt);
            check($sformatf("vec%0d_latency", i),  lat,      vecs[i].lat);
            check($sformatf("vec%0d_busy", i),     bcnt,     vecs[i].lat - 1);
            check($sformatf("vec%0d_result", i),   result,   vecs[i].r);
            check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d_err", i),      err,      vecs[i].err);
            tick();
            check($sformatf("vec%0d_hold", i),     result,   vecs[i].r);
            pulse_enter(4'd0, 2'b00);
            check($sformatf("vec%0d_clear", i),    result,   0);
            check($sformatf("vec%0d_err_clr", i),  err,      0);
            do_reset();
        end

        // Enter pulses during EXEC/MUL are ignored
        pulse_enter(4'd15, 2'b00);
        pulse_enter(4'd15, 2'b10);
        wait_done(1'b1, lat, bcnt);
        check("ign_latency", lat,    6);
        check("ign_result",  result, 8'hE1);
        check("ign_state",   state,  ST_DONE);
        do_reset();

        // Reset during the 2nd MUL cycle
        pulse_enter(4'd15, 2'b00);
        pulse_enter(4'd15, 2'b10);
        tick();
        tick();
        check("rmul_in_mul", state, ST_MUL);
        do_reset();
        check("rmul_state",  state,  ST_GET_A);
        check("rmul_result", result, 0);
        check("rmul_busy",   busy,   0);
        check("rmul_done",   done,   0);
        pulse_enter(4'd2, 2'b00);
        pulse_enter(4'd3, 2'b10);
        wait_done(1'b0, lat, bcnt);
        check("rmul_after_lat",    lat,    6);
        check("rmul_after_result", result, 8'h06);

        // Chaining behaviour of enter in DONE
        do_reset();
        pulse_enter(4'd3, 2'b00);
        pulse_enter(4'd2, 2'b00);
        wait_done(1'b0, lat, bcnt);
        check("chain_first", result, 8'h05);
        pulse_enter(4'd9, 2'b00);
        check("chain_cleared", result, 0);
`ifdef CALC_CHAIN_EN
        check("chain_state", state, ST_GET_B);
        pulse_enter(4'd4, 2'b01);
        wait_done(1'b0, lat, bcnt);
        check("chain_result", result, 8'h01);
`else
        check("chain_state", state, ST_GET_A);
        pulse_enter(4'd9, 2'b00);
        pulse_enter(4'd4, 2'b01);
        wait_done(1'b0, lat, bcnt);
        check("chain_result", result, 8'h05);
`endif

        // Randomized operations against the reference model
        do_reset();
        have_a = 1'b0;
        a_cur  = '0;
        for (int n = 0; n < 60; n++) begin
            logic [3:0] b_v;
            logic [1:0] o_v;
            if (!have_a) begin
                a_cur = 4'($urandom);
                pulse_enter(a_cur, 2'($urandom));
            end
            b_v = 4'($urandom);
            o_v = 2'($urandom);
            ref_model(a_cur, b_v, o_v, er, eo, ee, el);
            pulse_enter(b_v, o_v);
            wait_done(1'($urandom_range(0, 1)), lat, bcnt);
            check("rnd_latency",  lat,      el);
            check("rnd_result",   result,   er);
            check("rnd_overflow", overflow, eo);
            check("rnd_err",      err,      ee);
            pulse_enter(4'($urandom), 2'b00);
`ifdef CALC_CHAIN_EN
            check("rnd_exit_state", state, ST_GET_B);
            a_cur  = er[3:0];
            have_a = 1'b1;
`else
            check("rnd_exit_state", state, ST_GET_A);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM for the calculator datapath.
- Captures operand A, operand B and an opcode from board switches on debounced enter pulses.
- Sequences the external 4-bit add/sub unit: one pass for add/sub, a 4-iteration shift-add loop for unsigned multiply.
- Holds an 8-bit result plus status flags for the display block.

Parameters:
- WIDTH, 4, operand width; must equal the adder width; only 4 is supported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sw  in  WIDTH  operand value from switches
- op  in  2  opcode, sampled with B: 00 add, 01 sub, 10 mul, 11 reserved
- enter  in  1  single-cycle debounced button pulse
- add_x  out  WIDTH  adder operand x (combinational from state/regs)
- add_y  out  WIDTH  adder operand y
- add_sub  out  1  adder mode: 1 = subtract
- add_res  in  WIDTH  adder sum
- add_cout  in  1  adder carry-out
- add_ovf  in  1  adder signed overflow
- result  out  2*WIDTH  final result, registered
- overflow  out  1  signed overflow of last add/sub, registered
- err  out  1  reserved opcode used, registered
- busy  out  1  high in EXEC and MUL
- done  out  1  high in DONE
- state  out  3  state encoding for debug LEDs

Behaviour:
- Reset state: rst_n=0 at a clk edge gives state=GET_A and clears A, B, opcode, mul counter, accumulator, result, overflow, err, busy and done.
- rst_n is sampled only at clk edges; asserting it mid-multiply aborts the loop with no partial result kept.
- Adder ports are combinational from state and regs. Outside EXEC and MUL: add_x=0, add_y=0, add_sub=0.
- GET_A: enter loads A<=sw, then go to GET_B.
- GET_B: enter loads B<=sw and opcode<=op, then go to EXEC.
- Any enter outside GET_A, GET_B and DONE is ignored.
- EXEC, one cycle:
  - add/sub: add_x=A, add_y=B, add_sub=opcode[0]. Register result<={{WIDTH{add_res[3]}},add_res} (sign-extended), overflow<=add_ovf, err<=0. Go to DONE.
  - mul: init ACC<=0, Q<=B, cnt<=0, overflow<=0, err<=0. Go to MUL.
  - reserved: result<=0, overflow<=0, err<=1. Go to DONE.
- MUL, unsigned shift-add, one iteration per cycle:
  - add_x=ACC, add_y=A, add_sub=0.
  - If Q[0]: {C,ACC,Q} <= {add_cout,add_res,Q} >> 1. Else: {C,ACC,Q} <= {1'b0,ACC,Q} >> 1.
  - cnt increments each iteration. After the 4th iteration (cnt==3), result<={ACC',Q'} using the post-shift values, then go to DONE.
- DONE: result and flags held. enter clears result, overflow and err, then goes to GET_A.
- Latency from the enter that captures B:
  - add/sub/reserved: done high 2 cycles later.
  - mul: done high 6 cycles later (EXEC + 4 MUL).
- Arithmetic rules:
  - add/sub treat operands as 4-bit two's complement.
  - mul treats operands as unsigned (0..15), product 0..225; overflow is never set.
- No wrap-around of the result register; it is written only in EXEC (add/sub/reserved) and on the last MUL cycle.

Optional Feature:
- Macro: CALC_CHAIN_EN
- Defined: in DONE, enter loads A<=result[WIDTH-1:0], clears flags and goes to GET_B, so the previous answer is the next operand A.
- Not defined: DONE + enter goes to GET_A with A unchanged until the next enter there.

Test Plan:
- Add: A=3, B=2, op=00 → 2 cycles after B enter: done=1, result=8'h05, overflow=0, err=0.
- Subtract: A=3, B=5, op=01 → result=8'hFE (-2), overflow=0. Then A=7, B=1, op=00 → result=8'hF8, overflow=1.
- Multiply: A=15, B=15, op=10 → busy=1 for 5 cycles, done 6 cycles after B enter, result=8'hE1 (225). Also A=0, B=9 → result=8'h00.
- Reserved opcode and ignored enter: op=11 → result=8'h00, err=1. An enter pulse during MUL → no state change, final product unaffected.
- Reset mid-multiply: rst_n=0 for 1 cycle during the 2nd MUL cycle → next cycle state=GET_A, result=0, busy=0, done=0. A following 2×3 multiply gives 8'h06.
- Chain (CALC_CHAIN_EN defined): 3+2=5, then enter in DONE → state=GET_B with A=5; B=4, op=01 → result=8'h01. With the macro undefined, the same enter → state=GET_A.
